// File: rtl/mem_port_arbiter_pkg.sv
// Shared CPU memory definitions: word size, arbiter state and owner encodings.
package mem_port_arbiter_pkg;

   localparam int unsigned WORD_SIZE = 16;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StRd      = 2'd1,
      StWr      = 2'd2,
      StRelease = 2'd3
   } state_e;

   typedef enum logic {
      OwnFetch = 1'b0,
      OwnData  = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_wait_timer.sv
// Wait counter for one memory access; flags the cycle that completes MAX_WAIT cycles.
module mem_wait_timer #(
   parameter int unsigned MAX_WAIT = 15,
   parameter int unsigned TW       = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);

   logic [TW-1:0] cnt_q, cnt_d;

   // cnt_q holds the number of completed cycles in the access state
   assign expired_o = en_i && (cnt_q == TW'(MAX_WAIT - 1));

   // Next count: clear outside an access, otherwise count up
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && !expired_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register with synchronous reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single four-phase memory port between instruction fetch and data access.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned MAX_WAIT  = 15,
   parameter int unsigned TW        = 4
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 i_req,
   input  logic [WORD_SIZE-1:0] i_addr,
   output logic                 i_done,
   output logic [WORD_SIZE-1:0] i_rdata,
   input  logic                 d_req,
   input  logic                 d_we,
   input  logic [WORD_SIZE-1:0] d_addr,
   input  logic [WORD_SIZE-1:0] d_wdata,
   output logic                 d_done,
   output logic [WORD_SIZE-1:0] d_rdata,
   output logic                 err,
   output logic                 busy,
   output logic                 readM,
   output logic                 writeM,
   output logic [WORD_SIZE-1:0] address,
   inout  wire  [WORD_SIZE-1:0] data,
   input  logic                 inputReady,
   input  logic                 ackOutput
);

   state_e               state_q;
   owner_e               owner_q;
   logic                 read_q, write_q, drive_q;
   logic                 i_done_q, d_done_q, err_q, busy_q;
   logic [WORD_SIZE-1:0] addr_q, wdata_q, i_rdata_q, d_rdata_q;
   logic                 tmr_en, tmr_expired;

   assign tmr_en = (state_q == StRd) || (state_q == StWr);

   mem_wait_timer #(
      .MAX_WAIT(MAX_WAIT),
      .TW      (TW)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr_i    (!tmr_en),
      .en_i     (tmr_en),
      .expired_o(tmr_expired)
   );

   assign data    = drive_q ? wdata_q : {WORD_SIZE{1'bz}};
   assign readM   = read_q;
   assign writeM  = write_q;
   assign address = addr_q;
   assign i_done  = i_done_q;
   assign d_done  = d_done_q;
   assign i_rdata = i_rdata_q;
   assign d_rdata = d_rdata_q;
   assign err     = err_q;
   assign busy    = busy_q;

   // Access sequencer: grant, wait for acknowledge or timeout, then wait for ack release
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= StIdle;
         owner_q   <= OwnFetch;
         read_q    <= 1'b0;
         write_q   <= 1'b0;
         drive_q   <= 1'b0;
         i_done_q  <= 1'b0;
         d_done_q  <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         i_rdata_q <= '0;
         d_rdata_q <= '0;
      end else begin
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         err_q    <= 1'b0;
         case (state_q)
            StIdle: begin
               // Data wins over fetch
               if (d_req) begin
                  owner_q <= OwnData;
                  addr_q  <= d_addr;
                  busy_q  <= 1'b1;
                  if (d_we) begin
                     write_q <= 1'b1;
                     drive_q <= 1'b1;
                     wdata_q <= d_wdata;
                     state_q <= StWr;
                  end else begin
                     read_q  <= 1'b1;
                     state_q <= StRd;
                  end
               end else if (i_req) begin
                  owner_q <= OwnFetch;
                  addr_q  <= i_addr;
                  busy_q  <= 1'b1;
                  read_q  <= 1'b1;
                  state_q <= StRd;
               end
            end
            StRd: begin
               // An acknowledge on the timeout edge still completes normally
               if (inputReady || tmr_expired) begin
                  read_q  <= 1'b0;
                  err_q   <= !inputReady;
                  state_q <= StRelease;
                  if (owner_q == OwnData) begin
                     d_done_q  <= 1'b1;
                     d_rdata_q <= inputReady ? data : '0;
                  end else begin
                     i_done_q  <= 1'b1;
                     i_rdata_q <= inputReady ? data : '0;
                  end
               end
            end
            StWr: begin
               if (ackOutput || tmr_expired) begin
                  write_q <= 1'b0;
                  drive_q <= 1'b0;
                  err_q   <= !ackOutput;
                  state_q <= StRelease;
                  if (owner_q == OwnData) begin
                     d_done_q <= 1'b1;
                     if (!ackOutput) d_rdata_q <= '0;
                  end else begin
                     i_done_q <= 1'b1;
                     if (!ackOutput) i_rdata_q <= '0;
                  end
               end
            end
            StRelease: begin
               // Four-phase: memory must drop its acknowledge before the next grant
               if (!inputReady && !ackOutput) begin
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a four-phase memory model and scoreboard.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
   logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
   logic        i_done, d_done, err, busy, readM, writeM;
   logic [15:0] i_rdata, d_rdata, address;
   wire  [15:0] data_bus;
   logic        inputReady = 1'b0, ackOutput = 1'b0;

   // memory model state
   logic [15:0] mem [0:255];
   logic        mem_drive = 1'b0;
   logic [15:0] mem_word = '0;
   int          ack_delay = 3;
   int          hold_extra = 0;
   bit          never_ack = 1'b0;
   int          wait_cnt = 0;
   int          hold_cnt = 0;

   int n_total = 0;
   int n_bad = 0;

   typedef struct packed {
      logic        is_data;
      logic        chk_rd;
      logic [15:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb_q[$];

   assign data_bus = mem_drive ? mem_word : 16'bz;

   mem_port_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_done    (i_done),
      .i_rdata   (i_rdata),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_done    (d_done),
      .d_rdata   (d_rdata),
      .err       (err),
      .busy      (busy),
      .readM     (readM),
      .writeM    (writeM),
      .address   (address),
      .data      (data_bus),
      .inputReady(inputReady),
      .ackOutput (ackOutput)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_done(input bit is_data, input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (is_data ? d_done : i_done) seen = 1'b1;
      end
      if (!seen) check(tag, 32'd0, 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      bit seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         tick();
         if (!busy) seen = 1'b1;
      end
      if (!seen) check(tag, 32'd0, 32'd1);
   endtask

   // Memory model: acknowledges after ack_delay strobe cycles, holds ack for hold_extra cycles
   initial begin
      for (int i = 0; i < 256; i++) mem[i] = '0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            inputReady = 1'b0;
            ackOutput  = 1'b0;
            mem_drive  = 1'b0;
            wait_cnt   = 0;
            hold_cnt   = 0;
         end else if (readM || writeM) begin
            if (!inputReady && !ackOutput) begin
               wait_cnt++;
               if (!never_ack && wait_cnt >= ack_delay) begin
                  if (readM) begin
                     mem_word   = mem[address[7:0]];
                     mem_drive  = 1'b1;
                     inputReady = 1'b1;
                  end else begin
                     mem[address[7:0]] = data_bus;
                     ackOutput = 1'b1;
                  end
               end
            end
         end else begin
            if (inputReady || ackOutput) begin
               if (hold_cnt < hold_extra) begin
                  hold_cnt++;
               end else begin
                  inputReady = 1'b0;
                  ackOutput  = 1'b0;
                  mem_drive  = 1'b0;
                  hold_cnt   = 0;
               end
            end
            wait_cnt = 0;
         end
      end
   end

   // Scoreboard monitor: every done pulse must match the oldest expected completion
   always @(negedge clk) begin
      if (reset_n && (i_done || d_done)) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("done_owner", {30'd0, d_done, i_done}, e.is_data ? 32'd2 : 32'd1);
            check("done_err", {31'd0, err}, {31'd0, e.err});
            if (e.chk_rd)
               check("done_rdata", {16'd0, e.is_data ? d_rdata : i_rdata}, {16'd0, e.rdata});
         end
      end else if (reset_n && err) begin
         check("stray_err", 32'd1, 32'd0);
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      exp_t e;
      mem[0] = 16'h530a;
      mem[4] = 16'hf300;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_readM", {31'd0, readM}, 32'd0);
      check("rst_writeM", {31'd0, writeM}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_address", {16'd0, address}, 32'd0);
      check("rst_dones", {30'd0, i_done, d_done}, 32'd0);
      check("rst_rdata", {i_rdata, d_rdata}, 32'd0);
      tick();
      reset_n = 1'b1;
      tick();

      // fetch read
      i_req = 1'b1; i_addr = 16'd0;
      e = '{is_data: 1'b0, chk_rd: 1'b1, rdata: 16'h530a, err: 1'b0};
      sb_q.push_back(e);
      tick();
      check("fetch_readM", {31'd0, readM}, 32'd1);
      check("fetch_addr", {16'd0, address}, 32'd0);
      check("fetch_writeM", {31'd0, writeM}, 32'd0);
      check("fetch_busy", {31'd0, busy}, 32'd1);
      wait_done(1'b0, "fetch_done_timeout");
      i_req = 1'b0;
      wait_idle("fetch_idle_timeout");

      // data write
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'd32; d_wdata = 16'd10;
      e = '{is_data: 1'b1, chk_rd: 1'b0, rdata: 16'h0, err: 1'b0};
      sb_q.push_back(e);
      tick();
      check("wr_writeM", {31'd0, writeM}, 32'd1);
      check("wr_readM", {31'd0, readM}, 32'd0);
      check("wr_bus", {16'd0, data_bus}, 32'h000a);
      check("wr_addr", {16'd0, address}, 32'd32);
      tick();
      check("wr_bus_hold", {16'd0, data_bus}, 32'h000a);
      wait_done(1'b1, "wr_done_timeout");
      d_req = 1'b0; d_we = 1'b0;
      wait_idle("wr_idle_timeout");
      check("wr_mem", {16'd0, mem[32]}, 32'd10);
      check("wr_writeM_low", {31'd0, writeM}, 32'd0);

      // contention: data read first, fetch two edges after its done
      i_req = 1'b1; i_addr = 16'd4;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'd32;
      e = '{is_data: 1'b1, chk_rd: 1'b1, rdata: 16'd10, err: 1'b0};
      sb_q.push_back(e);
      e = '{is_data: 1'b0, chk_rd: 1'b1, rdata: 16'hf300, err: 1'b0};
      sb_q.push_back(e);
      tick();
      check("cont_first_addr", {16'd0, address}, 32'd32);
      wait_done(1'b1, "cont_d_done_timeout");
      d_req = 1'b0;
      tick();
      check("cont_gap_readM", {31'd0, readM}, 32'd0);
      tick();
      check("cont_regrant_readM", {31'd0, readM}, 32'd1);
      check("cont_regrant_addr", {16'd0, address}, 32'd4);
      wait_done(1'b0, "cont_i_done_timeout");
      i_req = 1'b0;
      wait_idle("cont_idle_timeout");

      // timeout on a data read
      never_ack = 1'b1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'd5;
      e = '{is_data: 1'b1, chk_rd: 1'b1, rdata: 16'h0, err: 1'b1};
      sb_q.push_back(e);
      tick();
      begin
         int n = 0;
         while (readM && n < 40) begin
            tick();
            n++;
         end
         check("to_cycles_in_rd", n, 32'd15);
         check("to_done_err", {30'd0, d_done, err}, 32'd3);
      end
      @(negedge clk);
      d_req = 1'b0;
      wait_idle("to_idle_timeout");
      never_ack = 1'b0;

      // reset in the middle of a write, with a fetch pending
      never_ack = 1'b1;
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'd40; d_wdata = 16'h1234;
      tick();
      check("rstw_writeM", {31'd0, writeM}, 32'd1);
      tick();
      reset_n = 1'b0;
      i_req = 1'b1; i_addr = 16'd0;
      tick();
      check("rstw_writeM_low", {31'd0, writeM}, 32'd0);
      check("rstw_busy", {31'd0, busy}, 32'd0);
      check("rstw_no_done", {31'd0, d_done}, 32'd0);
      d_req = 1'b0; d_we = 1'b0;
      never_ack = 1'b0;
      tick();
      reset_n = 1'b1;
      e = '{is_data: 1'b0, chk_rd: 1'b1, rdata: 16'h530a, err: 1'b0};
      sb_q.push_back(e);
      wait_done(1'b0, "rstw_fetch_timeout");
      i_req = 1'b0;
      wait_idle("rstw_idle_timeout");
      check("rstw_mem_untouched", {16'd0, mem[40]}, 32'd0);

      // four-phase hold: inputReady lingers, pending fetch must wait
      hold_extra = 2;
      i_req = 1'b1; i_addr = 16'd4;
      e = '{is_data: 1'b0, chk_rd: 1'b1, rdata: 16'hf300, err: 1'b0};
      sb_q.push_back(e);
      wait_done(1'b0, "hold_first_timeout");
      i_req = 1'b0;
      e = '{is_data: 1'b0, chk_rd: 1'b1, rdata: 16'h530a, err: 1'b0};
      sb_q.push_back(e);
      for (int k = 1; k <= 3; k++) begin
         tick();
         if (k == 1) begin
            i_req = 1'b1; i_addr = 16'd0;
         end
         check("hold_no_strobe", {31'd0, readM}, 32'd0);
         check("hold_busy", {31'd0, busy}, (k < 3) ? 32'd1 : 32'd0);
      end
      tick();
      check("hold_grant_readM", {31'd0, readM}, 32'd1);
      check("hold_grant_addr", {16'd0, address}, 32'd0);
      wait_done(1'b0, "hold_second_timeout");
      i_req = 1'b0;
      hold_extra = 0;
      wait_idle("hold_idle_timeout");

      repeat (3) tick();
      check("sb_empty", sb_q.size(), 32'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single CPU memory port (readM/writeM/address/data with inputReady/ackOutput acknowledges) between two requesters: instruction fetch (read-only) and data access (read/write).
- Sequences each access as a four-phase handshake and returns the result to the owning requester with a one-cycle done pulse.
- Includes a watchdog that terminates accesses the memory never acknowledges.
- Sits between the multi-cycle/pipelined CPU control and the external memory model.

Parameters:
- WORD_SIZE, 16, width of address and data words.
- MAX_WAIT, 15, clock cycles allowed in an access state before timeout.
- TW, 4, width of the wait counter; must satisfy 2^TW > MAX_WAIT.

Ports:
- clk  in  1  clock
- reset_n  in  1  reset, synchronous, active-low
- i_req  in  1  fetch request; held high, with i_addr stable, until i_done
- i_addr  in  WORD_SIZE  fetch address
- i_done  out  1  one-cycle completion pulse for fetch
- i_rdata  out  WORD_SIZE  fetched word; valid only while i_done=1
- d_req  in  1  data request; held high, with d_we/d_addr/d_wdata stable, until d_done
- d_we  in  1  1=write, 0=read
- d_addr  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  write data
- d_done  out  1  one-cycle completion pulse for data access
- d_rdata  out  WORD_SIZE  read word; valid only while d_done=1
- err  out  1  timeout flag; pulses together with the done pulse of a timed-out access
- busy  out  1  high in any state other than IDLE
- readM  out  1  memory read strobe
- writeM  out  1  memory write strobe
- address  out  WORD_SIZE  memory address
- data  inout  WORD_SIZE  memory data bus
- inputReady  in  1  memory read acknowledge, level-held
- ackOutput  in  1  memory write acknowledge, level-held

Behaviour:
- Reset (synchronous, reset_n=0 at posedge): state=IDLE; readM=writeM=0; address=0; data bus Z; i_done=d_done=err=0; busy=0; i_rdata=d_rdata=0; wait counter cleared.
- All outputs are registered.
- Memory protocol is four-phase:
  - The memory holds inputReady/ackOutput high until the strobe drops.
  - Acknowledges are sampled only at posedge clk.
- States: IDLE, RD, WR, RELEASE.
- IDLE arbitration at each posedge:
  - Fixed priority: data over fetch.
  - If d_req=1: latch owner=DATA and d_addr. Go to WR if d_we=1 (writeM=1, latch d_wdata), else RD (readM=1).
  - Else if i_req=1: owner=FETCH, latch i_addr, go to RD (readM=1).
  - Strobe and address rise on the same edge that samples the request.
- RD:
  - address held; data bus Z.
  - On the edge sampling inputReady=1: capture data into the owner's rdata, pulse owner's done, readM=0, go to RELEASE.
- WR:
  - Bus driven with the latched word for the entire state.
  - On the edge sampling ackOutput=1: writeM=0, release bus to Z, pulse owner's done, go to RELEASE.
- Timeout (RD or WR): the counter increments each cycle. When it reaches MAX_WAIT without an acknowledge:
  - Drop the strobe and pulse owner's done with err=1.
  - Owner's rdata=0.
  - Go to RELEASE.
- RELEASE:
  - Strobes low, bus Z.
  - Minimum one cycle.
  - Go to IDLE on the first edge where both inputReady and ackOutput are sampled 0.
  - Requests are not sampled in this state.
- Requester rules:
  - Deassert req on the edge following done.
  - A req still high when IDLE is re-entered is a new access.
- Minimum latency: request sampled at edge t0, acknowledge sampled at edge t1 ≥ t0+1, done high during cycle t1..t1+1. Earliest next grant is edge t1+2.
- Simultaneous requests: data is served first; fetch is served on the first IDLE edge after.
- Fetch starvation under continuous d_req is permitted; the CPU guarantees gaps.
- Reset mid-access: abort immediately. No done pulse; strobes drop; bus Z on the next edge.
- Address width equals WORD_SIZE; no arithmetic on addresses.

Decomposition:
- Shared package (cpu memory defs) holds:
  - WORD_SIZE
  - state encoding localparams for IDLE/RD/WR/RELEASE
  - owner encoding FETCH/DATA
- One sub-module, mem_wait_timer: TW-bit counter with clear, enable and a terminal flag at MAX_WAIT.

Test Plan:
- Fetch read: memory[0]=16'h530a; i_req=1, i_addr=0; model raises inputReady 3 cycles later.
  - Response: readM high with address=0 from the sampling edge; one-cycle i_done with i_rdata=16'h530a; writeM stays 0; data bus Z.
- Data write: d_req=1, d_we=1, d_addr=32, d_wdata=10.
  - Response: writeM=1 with data=16'h000a driven until ackOutput is sampled; memory[32]=10; d_done pulses with err=0; bus Z afterwards.
- Contention: i_req (addr 4, memory[4]=16'hf300) and d_req read (addr 32) rise on the same edge.
  - Response: d_done with d_rdata=10 first; readM then re-asserts with address=4 two edges later; i_done with i_rdata=16'hf300.
- Timeout: model never acknowledges a d_req read of addr 5.
  - Response: after 15 cycles in RD, readM drops; d_done=1 and err=1 on the same cycle; d_rdata=0; block returns to IDLE.
- Reset mid-write: reset_n=0 while in WR.
  - Response: next edge writeM=0, bus Z, no d_done; after reset_n=1, a pending i_req is served normally.
- Four-phase hold: model keeps inputReady high 2 cycles after readM drops, with i_req pending.
  - Response: block stays in RELEASE with busy=1 and no new strobe until inputReady is sampled 0; then the pending fetch is granted.
